// File: rtl/life_pkg.sv
// Shared types for the Game-of-Life step controller.
// Latency: none; this package holds types and constants only.
// Backpressure: none.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        STEP  = 3'd4
    } state_t;

    typedef logic [15:0] gen_count_t;

    localparam gen_count_t GEN_MAX = 16'hFFFF;

endpackage

// File: rtl/life_tick_gen.sv
// Generation tick timer: counts 0..TICK_MAX-1 while en is high and wraps to 0.
// Latency: tick is combinational and is high in the cycle the count sits at TICK_MAX-1.
// Backpressure: none; en=0 freezes the count and clr forces it to 0.
module life_tick_gen #(
    parameter int unsigned TICK_MAX = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_MAX);
    localparam logic [CW-1:0] LAST = CW'(TICK_MAX - 1);

    logic [CW-1:0] r_count;

    // Free-running count while enabled, wrapping at LAST; clr takes priority over en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign tick = en & ~clr & (r_count == LAST);

endmodule

// File: rtl/life_step_ctrl.sv
// Game-of-Life sequencer: seeds the grid, then advances it on a timer (RUN) or by button (STEP).
// Latency: strobes are combinational from the registered state; state changes one cycle after its cause.
// Backpressure: none; optional generation counter is built when LIFE_GEN_COUNT_EN is defined.
module life_step_ctrl
    import life_pkg::*;
#(
    parameter int unsigned TICK_MAX = 25_000_000
) (
    input  logic        clk,
    input  logic        fsmReset_n,
    input  logic        startSwitch,
    input  logic        randSwitch,
    input  logic        stepBtn,
    input  logic        clearBtn,
    output logic        lfsrEn,
    output logic        seedLoad,
    output logic        seedSel,
    output logic        gridEn,
    output logic        running,
    output logic [15:0] genCount
);

    state_t r_state;
    state_t w_next;
    logic   r_step_d;
    logic   r_run_d;
    logic   r_seed_sel;
    logic   w_step_rise;
    logic   w_tick;
    logic   w_tick_clr;
    logic   w_tick_en;
    logic   w_seed_load;
    logic   w_grid_en;

    assign w_step_rise = stepBtn & ~r_step_d;

    // The counter is held at 0 for the whole first RUN cycle, so every entry to RUN
    // (from LOAD or PAUSE) waits a full TICK_MAX cycles before the first tick.
    assign w_tick_en  = (r_state == RUN);
    assign w_tick_clr = clearBtn | ((r_state == RUN) & ~r_run_d);

    life_tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (fsmReset_n),
        .clr   (w_tick_clr),
        .en    (w_tick_en),
        .tick  (w_tick)
    );

    // State register, stepBtn history (reset high so a held button cannot step), seed select.
    always_ff @(posedge clk) begin
        if (!fsmReset_n) begin
            r_state    <= IDLE;
            r_step_d   <= 1'b1;
            r_run_d    <= 1'b0;
            r_seed_sel <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_step_d <= stepBtn;
            r_run_d  <= (r_state == RUN);
            if (w_seed_load) begin
                r_seed_sel <= randSwitch;
            end
        end
    end

    // Next-state and strobe decode; clearBtn overrides everything and suppresses strobes.
    always_comb begin
        w_next      = r_state;
        lfsrEn      = 1'b0;
        w_seed_load = 1'b0;
        w_grid_en   = 1'b0;
        case (r_state)
            IDLE: begin
                lfsrEn = 1'b1;
                if (startSwitch) w_next = LOAD;
            end
            LOAD: begin
                w_seed_load = 1'b1;
                w_next      = RUN;
            end
            RUN: begin
                if (!startSwitch) w_next = PAUSE;
                else if (w_tick)  w_grid_en = 1'b1;
            end
            PAUSE: begin
                if (startSwitch)      w_next = RUN;
                else if (w_step_rise) w_next = STEP;
            end
            STEP: begin
                w_grid_en = 1'b1;
                w_next    = PAUSE;
            end
            default: w_next = IDLE;
        endcase
        if (clearBtn) begin
            w_next      = IDLE;
            w_seed_load = 1'b0;
            w_grid_en   = 1'b0;
        end
    end

    assign seedLoad = w_seed_load;
    assign gridEn   = w_grid_en;
    assign seedSel  = r_seed_sel;
    assign running  = (r_state == RUN);

`ifdef LIFE_GEN_COUNT_EN
    gen_count_t r_gen_count;

    // Generations since the last seed load, saturating at GEN_MAX.
    always_ff @(posedge clk) begin
        if (!fsmReset_n) begin
            r_gen_count <= '0;
        end else if (clearBtn || w_seed_load) begin
            r_gen_count <= '0;
        end else if (w_grid_en && (r_gen_count != GEN_MAX)) begin
            r_gen_count <= r_gen_count + 16'd1;
        end
    end

    assign genCount = r_gen_count;
`else
    assign genCount = 16'h0000;
`endif

endmodule
